data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder end of the processor's data-memory port: accepts word load/store requests (address = ALU result, store data = second register operand) and returns load data.
- Word-addressed, synchronous storage with a configurable number of wait states.
- Single-outstanding request/response handshake, with error signalling for misaligned or out-of-range addresses.
- Sits between the datapath (or its bus adapter) and on-chip RAM.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words stored; power of two, at least 2.
- BASE_ADDR, 32'h10010000: byte address of word 0; word-aligned.
- WAIT_STATES, 2: extra cycles between acceptance and response, 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; asserted at 0.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_error  output  1  request was misaligned or out of range.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, wait counter=0.
  - Storage contents are not reset.
- State machine, states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. On req_valid && req_ready, latch write, addr and wdata, then go to WAIT if WAIT_STATES>0, else RESP. Load counter with WAIT_STATES-1.
  - WAIT: req_ready=0. Decrement counter each cycle; when counter==0, go to RESP next edge.
  - RESP: req_ready=0, resp_valid=1. resp_rdata and resp_error are stable until resp_ready=1, then return to IDLE on that edge.
- Latency and throughput:
  - Request accepted at edge T gives resp_valid high from edge T+1+WAIT_STATES.
  - Minimum spacing between accepted requests is 2+WAIT_STATES cycles; no pipelining.
  - req_ready is never high in the same cycle as resp_valid.
- Address check, on latched addr:
  - misaligned: addr[1:0] != 0.
  - out of range: addr < BASE_ADDR or addr >= BASE_ADDR + 4*DEPTH_WORDS. Compute the sum in 33 bits so no wrap-around occurs at the top of the address space.
  - Either condition sets resp_error=1 and resp_rdata=0; storage is unchanged.
- Word index = (addr - BASE_ADDR) >> 2, width clog2(DEPTH_WORDS).
- Store commit and load capture:
  - A store commits on the edge entering RESP.
  - A load captures the array word on that same edge.
  - Load-after-store to the same address returns the new value.
- Inputs req_* are ignored outside IDLE; changes while busy have no effect.
- Reset mid-operation:
  - A reset in WAIT aborts the request; a pending store is not performed.
  - A reset in RESP drops the response.
- resp_ready held high in advance: the response completes in its first RESP cycle.

Decomposition:
- Shared package:
  - state enum {IDLE, WAIT, RESP}.
  - Default constants for BASE_ADDR and DEPTH_WORDS, shared with the datapath's memory map.
  - Error-cause localparams (misaligned, out-of-range) for the bench.
- One natural sub-module, data_memory_array: DEPTH_WORDS×32 storage with synchronous write-enable and registered read, instantiated once.
- Control FSM and counter stay in the top.

Test Plan:
- Store 32'hDEADBEEF to 32'h10010004, then load the same address (WAIT_STATES=2) -> each resp_valid arrives 3 cycles after acceptance; load returns 32'hDEADBEEF with resp_error=0.
- Load from 32'h10010002 (misaligned) and from 32'h10011000 (DEPTH_WORDS=1024, one past the end) -> resp_error=1, resp_rdata=0; a following load of the neighbouring word shows it unmodified.
- WAIT_STATES=0, back-to-back requests with resp_ready tied to 1 -> response one edge after acceptance; req_ready=1 every second cycle.
- Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_error stay stable, req_ready=0; a new req_valid pulse is ignored and the array is unchanged.
- Store 32'h12345678 to 32'h10010010, assert reset=0 during WAIT -> outputs go to reset values immediately; a later load of 32'h10010010 returns the prior contents, not 32'h12345678.
- Address 32'hFFFFFFFC with BASE_ADDR=32'hFFFFF000 and DEPTH_WORDS=1024 -> in range, index 1023, no wrap; 32'h00000000 -> resp_error=1.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: memory map defaults, FSM
// encodings, error-cause bit positions and the address check helper.
package data_memory_responder_pkg;

   // Memory map shared with the datapath
   localparam int unsigned DMEM_DEPTH_WORDS = 1024;
   localparam logic [31:0] DMEM_BASE_ADDR   = 32'h1001_0000;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   // Bit positions inside an error-cause vector
   localparam int unsigned ERR_MISALIGNED   = 0;
   localparam int unsigned ERR_OUT_OF_RANGE = 1;

   typedef struct packed {
      logic [1:0] state;
      logic [3:0] wait_cnt;
      logic [1:0] err_cause;
   } dmem_dbg_t;

   // The upper bound is formed in 33 bits so a window ending at 4 GiB does not wrap.
   function automatic logic [1:0] dmem_err_cause(input logic [31:0] addr,
                                                 input logic [31:0] base,
                                                 input logic [32:0] span);
      logic [1:0] cause;
      cause = '0;
      cause[ERR_MISALIGNED]   = (addr[1:0] != 2'b00);
      cause[ERR_OUT_OF_RANGE] = (addr < base) || ({1'b0, addr} >= ({1'b0, base} + span));
      return cause;
   endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response port between the datapath (master) and the data-memory
// responder (slave).
interface data_memory_responder_if;
   // A transfer happens on a rising edge where valid and ready are both 1;
   // valid never waits for ready, and payload is held stable while valid is 1.
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/data_memory_array.sv
// DEPTH_WORDS x 32 word storage with synchronous write and registered read.
// Contents are deliberately not reset.
module data_memory_array #(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic             re_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[idx_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one word load/store at a time, inserts
// WAIT_STATES idle cycles, then holds the response until the requester takes it.
module data_memory_responder
   import data_memory_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
   parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   data_memory_responder_if.slave        bus,
   output dmem_dbg_t                     dbg_o
);

   localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  WS_M1      = 4'(WAIT_STATES - 1);

   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             write_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [1:0]       cause_q;
   logic             rd_sel_q;

   logic             idle;
   logic             in_resp;
   logic             commit;
   logic             acc_write;
   logic [31:0]      acc_addr;
   logic [31:0]      acc_wdata;
   logic [1:0]       acc_cause;
   logic             acc_err;
   logic [IDX_W-1:0] acc_idx;
   logic [31:0]      arr_rdata;

   assign idle    = (state_q == ST_IDLE);
   assign in_resp = (state_q == ST_RESP);

   // With no wait states the access commits on the accepting edge, so it must
   // use the live request rather than the latched copy.
   assign acc_write = idle ? bus.req_write : write_q;
   assign acc_addr  = idle ? bus.req_addr  : addr_q;
   assign acc_wdata = idle ? bus.req_wdata : wdata_q;
   assign acc_cause = dmem_err_cause(acc_addr, BASE_ADDR, SPAN_BYTES);
   assign acc_err   = |acc_cause;
   assign acc_idx   = IDX_W'((acc_addr - BASE_ADDR) >> 2);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               cnt_d = WS_M1;
               if (WAIT_STATES == 0) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         write_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         cause_q  <= '0;
         rd_sel_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (idle && bus.req_valid) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
         end
         if (commit) begin
            cause_q  <= acc_cause;
            rd_sel_q <= !acc_write && !acc_err;
         end
      end
   end

   data_memory_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk_i   (clk),
      .we_i    (commit && acc_write && !acc_err),
      .re_i    (commit && !acc_write && !acc_err),
      .idx_i   (acc_idx),
      .wdata_i (acc_wdata),
      .rdata_o (arr_rdata)
   );

   // Stores and rejected requests answer with zero data
   assign bus.req_ready  = idle;
   assign bus.resp_valid = in_resp;
   assign bus.resp_error = in_resp && (|cause_q);
   assign bus.resp_rdata = (in_resp && rd_sel_q) ? arr_rdata : 32'd0;

   assign dbg_o = '{state: state_q, wait_cnt: cnt_q, err_cause: cause_q};

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three instances (WAIT_STATES 2/0/1, one at
// the top of the address space) checked every cycle against a transaction model.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS0 = 2;
  localparam int unsigned WS1 = 0;
  localparam int unsigned WS2 = 1;
  localparam logic [31:0] BASE_LO = 32'h1001_0000;
  localparam logic [31:0] BASE_HI = 32'hFFFF_F000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- per-instance bus signals ----------------
  logic [2:0]  req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
  logic [2:0]  ready_tie;
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [31:0] resp_rdata [3];
  dmem_dbg_t   dbg_w [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_responder_if bus ();
    assign bus.req_valid  = req_valid[g];
    assign bus.req_write  = req_write[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_wdata  = req_wdata[g];
    assign bus.resp_ready = resp_ready[g];
    assign req_ready[g]   = bus.req_ready;
    assign resp_valid[g]  = bus.resp_valid;
    assign resp_rdata[g]  = bus.resp_rdata;
    assign resp_error[g]  = bus.resp_error;

    data_memory_responder #(
      .DEPTH_WORDS (DEPTH),
      .BASE_ADDR   ((g == 2) ? BASE_HI : BASE_LO),
      .WAIT_STATES ((g == 0) ? WS0 : ((g == 1) ? WS1 : WS2))
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .dbg_o (dbg_w[g])
    );
  end

  // ---------------- scoreboard counters ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int unsigned ws_of(input int d);
    return (d == 0) ? WS0 : ((d == 1) ? WS1 : WS2);
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 2) ? BASE_HI : BASE_LO;
  endfunction

  // ---------------- transaction model ----------------
  // A request accepted at an edge is answered WAIT_STATES cycles later and the
  // answer is held until taken; the memory effect happens at that moment.
  bit          m_busy [3];
  int          m_age [3];
  bit          m_wr [3];
  logic [31:0] m_addr [3];
  logic [31:0] m_wd [3];
  logic [31:0] m_rd [3];
  bit          m_err [3];
  bit          m_chk [3];
  logic [31:0] mem_m [3][DEPTH];
  bit          known_m [3][DEPTH];

  task automatic model_access(input int d);
    longint unsigned a, b;
    int idx;
    a = m_addr[d];
    b = base_of(d);
    m_chk[d] = 1'b1;
    m_rd[d]  = 32'd0;
    m_err[d] = (a % 4 != 0) || (a < b) || (a >= b + 4 * DEPTH);
    if (!m_err[d]) begin
      idx = int'((a - b) / 4);
      if (m_wr[d]) begin
        mem_m[d][idx]   = m_wd[d];
        known_m[d][idx] = 1'b1;
      end else begin
        m_rd[d]  = mem_m[d][idx];
        m_chk[d] = known_m[d][idx];
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic ev;
      if (!reset) begin
        check($sformatf("d%0d reset req_ready", d), 32'(req_ready[d]), 32'd1);
        check($sformatf("d%0d reset resp_valid", d), 32'(resp_valid[d]), 32'd0);
        check($sformatf("d%0d reset resp_rdata", d), resp_rdata[d], 32'd0);
        check($sformatf("d%0d reset resp_error", d), 32'(resp_error[d]), 32'd0);
        m_busy[d] = 1'b0;
      end else begin
        ev = m_busy[d] && (m_age[d] >= int'(ws_of(d)));
        check($sformatf("d%0d req_ready", d), 32'(req_ready[d]), 32'(!m_busy[d]));
        check($sformatf("d%0d resp_valid", d), 32'(resp_valid[d]), 32'(ev));
        if (ev) begin
          check($sformatf("d%0d resp_error", d), 32'(resp_error[d]), 32'(m_err[d]));
          if (m_chk[d]) check($sformatf("d%0d resp_rdata", d), resp_rdata[d], m_rd[d]);
        end
        if (!m_busy[d]) begin
          if (req_valid[d]) begin
            m_busy[d] = 1'b1;
            m_age[d]  = 0;
            m_wr[d]   = req_write[d];
            m_addr[d] = req_addr[d];
            m_wd[d]   = req_wdata[d];
            if (ws_of(d) == 0) model_access(d);
          end
        end else if (ev) begin
          if (resp_ready[d]) m_busy[d] = 1'b0;
        end else begin
          m_age[d]++;
          if (m_age[d] == int'(ws_of(d))) model_access(d);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left at posedge+1. lat counts edges from acceptance to the
  // first edge that samples resp_valid high.
  task automatic do_req(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, input bit poke,
                        output logic [31:0] rd, output logic er, output int lat, output int acc_cyc);
    int n;
    req_write[d] = wr;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) check($sformatf("d%0d accept timeout", d), 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    acc_cyc = cyc;
    req_valid[d] = 1'b0;
    lat = 1;
    while (resp_valid[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (resp_valid[d] !== 1'b1) check($sformatf("d%0d response timeout", d), 32'(resp_valid[d]), 32'd1);
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) begin
        req_valid[d] = 1'b1;
        req_write[d] = 1'b1;
        req_wdata[d] = 32'hBADB_AD00;
      end else begin
        req_valid[d] = 1'b0;
      end
      @(posedge clk); #1;
    end
    req_valid[d]  = 1'b0;
    rd = resp_rdata[d];
    er = resp_error[d];
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = ready_tie[d];
  endtask

  // ---------------- directed stimulus ----------------
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t b2b [4];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, ac, ac_prev;

    reset = 1'b0;
    req_valid = '0; req_write = '0; resp_ready = '0; ready_tie = '0;
    for (int d = 0; d < 3; d++) begin
      req_addr[d] = '0;
      req_wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Store then load, two wait states
    do_req(0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 0, 1'b0, rd, er, lat, ac);
    check("store latency", lat, 32'd3);
    check("store rdata", rd, 32'd0);
    check("store error", 32'(er), 32'd0);
    do_req(0, 1'b0, 32'h1001_0004, 32'd0, 0, 1'b0, rd, er, lat, ac);
    check("load latency", lat, 32'd3);
    check("load rdata", rd, 32'hDEAD_BEEF);
    check("load error", 32'(er), 32'd0);

    // Error responses leave neighbours untouched
    do_req(0, 1'b1, 32'h1001_0000, 32'hA5A5_0000, 0, 1'b0, rd, er, lat, ac);
    do_req(0, 1'b1, 32'h1001_0FFC, 32'h0F0F_0F0F, 0, 1'b0, rd, er, lat, ac);
    do_req(0, 1'b0, 32'h1001_0002, 32'd0, 0, 1'b0, rd, er, lat, ac);
    check("misaligned load error", 32'(er), 32'd1);
    check("misaligned load rdata", rd, 32'd0);
    do_req(0, 1'b0, 32'h1001_1000, 32'd0, 0, 1'b0, rd, er, lat, ac);
    check("past-end load error", 32'(er), 32'd1);
    check("past-end load rdata", rd, 32'd0);
    do_req(0, 1'b1, 32'h1001_0002, 32'hFFFF_FFFF, 0, 1'b0, rd, er, lat, ac);
    check("misaligned store error", 32'(er), 32'd1);
    do_req(0, 1'b1, 32'h1001_1000, 32'hFFFF_FFFF, 0, 1'b0, rd, er, lat, ac);
    check("past-end store error", 32'(er), 32'd1);
    do_req(0, 1'b0, 32'h1001_0000, 32'd0, 0, 1'b0, rd, er, lat, ac);
    check("word 0 unchanged", rd, 32'hA5A5_0000);
    do_req(0, 1'b0, 32'h1001_0FFC, 32'd0, 0, 1'b0, rd, er, lat, ac);
    check("last word unchanged", rd, 32'h0F0F_0F0F);

    // Response held 5 cycles with an ignored store pulse in the middle
    do_req(0, 1'b0, 32'h1001_0004, 32'd0, 5, 1'b1, rd, er, lat, ac);
    check("held load rdata", rd, 32'hDEAD_BEEF);
    do_req(0, 1'b0, 32'h1001_0004, 32'd0, 0, 1'b0, rd, er, lat, ac);
    check("ignored store had no effect", rd, 32'hDEAD_BEEF);

    // Reset during WAIT aborts the store
    do_req(0, 1'b1, 32'h1001_0010, 32'h1111_1111, 0, 1'b0, rd, er, lat, ac);
    req_write[0] = 1'b1; req_addr[0] = 32'h1001_0010; req_wdata[0] = 32'h1234_5678;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async reset req_ready", 32'(req_ready[0]), 32'd1);
    check("async reset resp_valid", 32'(resp_valid[0]), 32'd0);
    check("async reset resp_rdata", resp_rdata[0], 32'd0);
    check("async reset resp_error", 32'(resp_error[0]), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    do_req(0, 1'b0, 32'h1001_0010, 32'd0, 0, 1'b0, rd, er, lat, ac);
    check("aborted store not performed", rd, 32'h1111_1111);

    // Zero wait states, resp_ready tied high, back-to-back
    ready_tie[1] = 1'b1;
    resp_ready[1] = 1'b1;
    b2b[0] = '{1'b1, 32'h1001_0100, 32'h0000_0001};
    b2b[1] = '{1'b0, 32'h1001_0100, 32'h0000_0001};
    b2b[2] = '{1'b1, 32'h1001_0104, 32'h0000_0002};
    b2b[3] = '{1'b0, 32'h1001_0104, 32'h0000_0002};
    ac_prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_req(1, b2b[i].wr, b2b[i].addr, b2b[i].wr ? b2b[i].data : 32'd0, 0, 1'b0, rd, er, lat, ac);
      check($sformatf("ws0 latency %0d", i), lat, 32'd1);
      if (i > 0) check($sformatf("ws0 spacing %0d", i), ac - ac_prev, 32'd2);
      check($sformatf("ws0 rdata %0d", i), rd, b2b[i].wr ? 32'd0 : b2b[i].data);
      ac_prev = ac;
    end

    // Window ending at the top of the address space
    do_req(2, 1'b1, 32'hFFFF_FFFC, 32'hCAFE_F00D, 0, 1'b0, rd, er, lat, ac);
    check("top store latency", lat, 32'd2);
    check("top store error", 32'(er), 32'd0);
    do_req(2, 1'b1, 32'hFFFF_F000, 32'h0BAD_F00D, 0, 1'b0, rd, er, lat, ac);
    do_req(2, 1'b0, 32'hFFFF_FFFC, 32'd0, 0, 1'b0, rd, er, lat, ac);
    check("top word rdata", rd, 32'hCAFE_F00D);
    check("top word error", 32'(er), 32'd0);
    do_req(2, 1'b0, 32'hFFFF_F000, 32'd0, 0, 1'b0, rd, er, lat, ac);
    check("top base rdata", rd, 32'h0BAD_F00D);
    do_req(2, 1'b0, 32'h0000_0000, 32'd0, 0, 1'b0, rd, er, lat, ac);
    check("addr zero error", 32'(er), 32'd1);
    check("addr zero rdata", rd, 32'd0);
    do_req(2, 1'b0, 32'hFFFF_EFFC, 32'd0, 0, 1'b0, rd, er, lat, ac);
    check("below base error", 32'(er), 32'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
